// File: rtl/bus_load_bank.sv
// Destination register bank on the common bus with a one-deep memory write handshake.
// Optional macro BUS_LOAD_LOST_WR_EN builds the sticky wr_lost flag for rejected memory writes.
module bus_load_bank #(
    parameter int AW = 12,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] bus_in,
    input  logic [2:0]    lsel,
    input  logic          ld_en,
    input  logic [5:0]    inc,
    input  logic [5:0]    clr,
    output logic [AW-1:0] ar_q,
    output logic [AW-1:0] pc_q,
    output logic [DW-1:0] dr_q,
    output logic [DW-1:0] ac_q,
    output logic [DW-1:0] ir_q,
    output logic [DW-1:0] tr_q,
    output logic          mem_wr_req,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_wr_ack,
    output logic          busy,
    output logic          wr_lost
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    localparam logic [2:0] SEL_MEM = 3'd7;

    state_t        r_state;
    logic [AW-1:0] r_ar;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_dr;
    logic [DW-1:0] r_ac;
    logic [DW-1:0] r_ir;
    logic [DW-1:0] r_tr;
    logic          r_req;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [7:0]    w_ld_hit;
    logic          w_mem_sel;

    // Next value of an address-width register: clear beats load beats increment.
    function automatic logic [AW-1:0] f_next_a(
        input logic [AW-1:0] cur,
        input logic          c,
        input logic          l,
        input logic          i,
        input logic [DW-1:0] b
    );
        logic [AW-1:0] nxt;
        if (c) begin
            nxt = {AW{1'b0}};
        end else if (l) begin
            nxt = b[AW-1:0];
        end else if (i) begin
            nxt = cur + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // Next value of a data-width register, same priority as above.
    function automatic logic [DW-1:0] f_next_d(
        input logic [DW-1:0] cur,
        input logic          c,
        input logic          l,
        input logic          i,
        input logic [DW-1:0] b
    );
        logic [DW-1:0] nxt;
        if (c) begin
            nxt = {DW{1'b0}};
        end else if (l) begin
            nxt = b;
        end else if (i) begin
            nxt = cur + {{(DW-1){1'b0}}, 1'b1};
        end else begin
            nxt = cur;
        end
        return nxt;
    endfunction

    // One-hot decode of the qualified destination select; bit 0 means no destination.
    always_comb begin
        w_ld_hit = 8'd0;
        if (ld_en) begin
            w_ld_hit[lsel] = 1'b1;
        end else begin
            w_ld_hit = 8'd0;
        end
    end

    assign w_mem_sel = ld_en && (lsel == SEL_MEM);

    // Register bank update.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ar <= {AW{1'b0}};
            r_pc <= {AW{1'b0}};
            r_dr <= {DW{1'b0}};
            r_ac <= {DW{1'b0}};
            r_ir <= {DW{1'b0}};
            r_tr <= {DW{1'b0}};
        end else begin
            r_ar <= f_next_a(r_ar, clr[0], w_ld_hit[1], inc[0], bus_in);
            r_pc <= f_next_a(r_pc, clr[1], w_ld_hit[2], inc[1], bus_in);
            r_dr <= f_next_d(r_dr, clr[2], w_ld_hit[3], inc[2], bus_in);
            r_ac <= f_next_d(r_ac, clr[3], w_ld_hit[4], inc[3], bus_in);
            r_ir <= f_next_d(r_ir, clr[4], w_ld_hit[5], inc[4], bus_in);
            r_tr <= f_next_d(r_tr, clr[5], w_ld_hit[6], inc[5], bus_in);
        end
    end

    // Memory write handshake; address is the pre-edge AR so same-edge AR updates don't leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_addr  <= {AW{1'b0}};
            r_wdata <= {DW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mem_sel) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_ar;
                        r_wdata <= bus_in;
                    end else begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (mem_wr_ack) begin
                        r_state <= ST_IDLE;
                        r_req   <= 1'b0;
                    end else begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end

`ifdef BUS_LOAD_LOST_WR_EN
    logic r_wr_lost;

    // Sticky flag: a memory write arrived while the previous one was still pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_lost <= 1'b0;
        end else if (w_mem_sel && (r_state == ST_REQ)) begin
            r_wr_lost <= 1'b1;
        end else begin
            r_wr_lost <= r_wr_lost;
        end
    end

    assign wr_lost = r_wr_lost;
`else
    assign wr_lost = 1'b0;
`endif

    assign ar_q       = r_ar;
    assign pc_q       = r_pc;
    assign dr_q       = r_dr;
    assign ac_q       = r_ac;
    assign ir_q       = r_ir;
    assign tr_q       = r_tr;
    assign mem_wr_req = r_req;
    assign busy       = r_req;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_bus_load_bank.sv
// Randomized bench for bus_load_bank against an array/flag reference model; directed cases first.
module tb_bus_load_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bus_in;
    logic [2:0]  lsel;
    logic        ld_en;
    logic [5:0]  inc;
    logic [5:0]  clr;
    logic [11:0] ar_q, pc_q, mem_addr;
    logic [15:0] dr_q, ac_q, ir_q, tr_q, mem_wdata;
    logic        mem_wr_req, mem_wr_ack, busy, wr_lost;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: index 1..6 = AR, PC, DR, AC, IR, TR (same numbering as lsel).
    int unsigned m_reg [1:6];
    bit          m_pend;
    int unsigned m_addr;
    int unsigned m_data;
    bit          m_lost;

    bus_load_bank dut (
        .clk(clk), .rst(rst), .bus_in(bus_in), .lsel(lsel), .ld_en(ld_en),
        .inc(inc), .clr(clr), .ar_q(ar_q), .pc_q(pc_q), .dr_q(dr_q),
        .ac_q(ac_q), .ir_q(ir_q), .tr_q(tr_q), .mem_wr_req(mem_wr_req),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr_ack(mem_wr_ack),
        .busy(busy), .wr_lost(wr_lost)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned width_mask(input int idx);
        return (idx <= 2) ? 32'h0000_0FFF : 32'h0000_FFFF;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        int unsigned ar_before;
        ar_before = m_reg[1];
        if (rst) begin
            for (int i = 1; i <= 6; i++) m_reg[i] = 0;
            m_pend = 0; m_addr = 0; m_data = 0; m_lost = 0;
        end else begin
            if (m_pend) begin
                if (ld_en && lsel == 3'd7) m_lost = 1;
                if (mem_wr_ack) m_pend = 0;
            end else if (ld_en && lsel == 3'd7) begin
                m_pend = 1;
                m_addr = ar_before;
                m_data = bus_in;
            end
            for (int i = 1; i <= 6; i++) begin
                if (clr[i-1])
                    m_reg[i] = 0;
                else if (ld_en && lsel == i[2:0])
                    m_reg[i] = bus_in & width_mask(i);
                else if (inc[i-1])
                    m_reg[i] = (m_reg[i] + 1) & width_mask(i);
            end
        end
    endtask

    task automatic check_all();
        bit exp_lost;
`ifdef BUS_LOAD_LOST_WR_EN
        exp_lost = m_lost;
`else
        exp_lost = 1'b0;
`endif
        chk("ar_q", {20'd0, ar_q}, m_reg[1]);
        chk("pc_q", {20'd0, pc_q}, m_reg[2]);
        chk("dr_q", {16'd0, dr_q}, m_reg[3]);
        chk("ac_q", {16'd0, ac_q}, m_reg[4]);
        chk("ir_q", {16'd0, ir_q}, m_reg[5]);
        chk("tr_q", {16'd0, tr_q}, m_reg[6]);
        chk("mem_wr_req", {31'd0, mem_wr_req}, {31'd0, m_pend});
        chk("busy", {31'd0, busy}, {31'd0, m_pend});
        chk("wr_lost", {31'd0, wr_lost}, {31'd0, exp_lost});
        if (m_pend) begin
            chk("mem_addr", {20'd0, mem_addr}, m_addr);
            chk("mem_wdata", {16'd0, mem_wdata}, m_data);
        end
    endtask

    task automatic apply(input logic r, input logic [15:0] b, input logic [2:0] ls,
                         input logic le, input logic [5:0] ic, input logic [5:0] cl,
                         input logic ak);
        rst = r; bus_in = b; lsel = ls; ld_en = le; inc = ic; clr = cl; mem_wr_ack = ak;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        for (int i = 1; i <= 6; i++) m_reg[i] = 0;
        m_pend = 0; m_addr = 0; m_data = 0; m_lost = 0;
        rst = 1'b1; bus_in = 16'h0000; lsel = 3'd0; ld_en = 1'b0;
        inc = 6'd0; clr = 6'd0; mem_wr_ack = 1'b0;

        apply(1'b1, 16'h0000, 3'd0, 1'b0, 6'd0, 6'd0, 1'b0);
        apply(1'b1, 16'h0000, 3'd0, 1'b0, 6'd0, 6'd0, 1'b0);
        chk("rst_req", {31'd0, mem_wr_req}, 32'd0);
        chk("rst_ac", {16'd0, ac_q}, 32'd0);

        // AR load discards upper bus bits
        apply(1'b0, 16'hABCD, 3'd1, 1'b1, 6'd0, 6'd0, 1'b0);
        chk("dir_ar", {20'd0, ar_q}, 32'h0BCD);
        chk("dir_pc0", {20'd0, pc_q}, 32'h0000);

        // PC wrap and AC clear-over-increment
        apply(1'b0, 16'hFFFF, 3'd2, 1'b1, 6'd0, 6'd0, 1'b0);
        apply(1'b0, 16'h1234, 3'd4, 1'b1, 6'd0, 6'd0, 1'b0);
        chk("dir_pcfff", {20'd0, pc_q}, 32'h0FFF);
        apply(1'b0, 16'h0000, 3'd0, 1'b0, 6'b001010, 6'b001000, 1'b0);
        chk("dir_pcwrap", {20'd0, pc_q}, 32'h0000);
        chk("dir_acclr", {16'd0, ac_q}, 32'h0000);

        // Load beats increment
        apply(1'b0, 16'h5A5A, 3'd3, 1'b1, 6'b000100, 6'd0, 1'b0);
        chk("dir_dr", {16'd0, dr_q}, 32'h5A5A);

        // Memory write with same-edge AR change, held 3 cycles, then a rejected write
        apply(1'b0, 16'h0010, 3'd1, 1'b1, 6'd0, 6'd0, 1'b0);
        apply(1'b0, 16'hBEEF, 3'd7, 1'b1, 6'b000001, 6'd0, 1'b1);
        chk("dir_addr", {20'd0, mem_addr}, 32'h0010);
        chk("dir_wdata", {16'd0, mem_wdata}, 32'hBEEF);
        chk("dir_req1", {31'd0, mem_wr_req}, 32'd1);
        chk("dir_ar11", {20'd0, ar_q}, 32'h0011);
        apply(1'b0, 16'h1111, 3'd7, 1'b1, 6'd0, 6'd0, 1'b0);
        chk("dir_req2", {31'd0, mem_wr_req}, 32'd1);
        chk("dir_keep", {16'd0, mem_wdata}, 32'hBEEF);
`ifdef BUS_LOAD_LOST_WR_EN
        chk("dir_lost", {31'd0, wr_lost}, 32'd1);
`else
        chk("dir_lost", {31'd0, wr_lost}, 32'd0);
`endif
        apply(1'b0, 16'h0000, 3'd0, 1'b0, 6'd0, 6'd0, 1'b0);
        chk("dir_req3", {31'd0, mem_wr_req}, 32'd1);
        apply(1'b0, 16'h2222, 3'd7, 1'b1, 6'd0, 6'd0, 1'b1);
        chk("dir_ackdrop", {31'd0, mem_wr_req}, 32'd0);
        apply(1'b0, 16'h3333, 3'd7, 1'b1, 6'd0, 6'd0, 1'b1);
        chk("dir_b2b", {31'd0, mem_wr_req}, 32'd1);
        chk("dir_b2bdata", {16'd0, mem_wdata}, 32'h3333);

        // Reset in the middle of a request, later ack ignored
        apply(1'b1, 16'h0000, 3'd0, 1'b0, 6'd0, 6'd0, 1'b0);
        chk("dir_rstreq", {31'd0, mem_wr_req}, 32'd0);
        chk("dir_rstdr", {16'd0, dr_q}, 32'd0);
        apply(1'b0, 16'h0000, 3'd0, 1'b0, 6'd0, 6'd0, 1'b1);
        chk("dir_lateack", {31'd0, mem_wr_req}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            logic       r_b, le_b, ak_b;
            logic [2:0] ls_b;
            logic [5:0] ic_b, cl_b;
            r_b  = ($urandom_range(0, 99) < 2);
            le_b = ($urandom_range(0, 99) < 60);
            ls_b = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            ak_b = ($urandom_range(0, 99) < 35);
            for (int k = 0; k < 6; k++) begin
                ic_b[k] = ($urandom_range(0, 5) == 0);
                cl_b[k] = ($urandom_range(0, 11) == 0);
            end
            apply(r_b, 16'($urandom), ls_b, le_b, ic_b, cl_b, ak_b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
